s1_bram_writer: RTL and testbench
=================================

S1_BRAM_WRITER -- requirements
Module: s1_bram_writer

Interface
REQ-001 Parameter IN_WIDTH, default 36, width of signed stage-1 result.
REQ-002 Parameter SHIFT, default 0, arithmetic right shift applied to each result before clamping (0..18).
REQ-003 clk  input  1  single system clock, all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  stage-1 result valid.
REQ-006 in_data  input  IN_WIDTH  signed stage-1 result.
REQ-007 in_last  input  1  producer marks final beat of an 8x8x3 frame.
REQ-008 in_ready  output  1  writer accepts the beat this cycle.
REQ-009 s2_busy  input  1  busy from the stage-2 consumer.
REQ-010 bram_we  output  1  BRAM port write enable.
REQ-011 bram_addr  output  8  BRAM word address, 0..191.
REQ-012 bram_din  output  17  unsigned BRAM write data.
REQ-013 data_done  output  1  one-cycle pulse: frame fully written.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_err  output  1  one-cycle pulse on in_last/beat-count mismatch.

Function
REQ-016 FSM states SHALL be IDLE, FILL, FLUSH, DONE, WAIT_ACK.
- IDLE->FILL when s2_busy=0; otherwise stay in IDLE.
- FILL->FLUSH on acceptance of beat 191.
- FLUSH->DONE->WAIT_ACK unconditionally, one cycle each.
- WAIT_ACK->IDLE when s2_busy=1.
REQ-017 in_ready SHALL equal (state==FILL); a beat is accepted iff in_valid&in_ready.
REQ-018 An 8-bit beat counter SHALL reset to 0 on entry to FILL and increment per accepted beat; address = counter = cha*64+row*8+col (col fastest).
REQ-019 Each accepted beat SHALL produce, on the next cycle, bram_we=1 with bram_addr = the beat's counter value and bram_din = the clamped data; otherwise bram_we=0 and addr/din hold their values.
REQ-020 Clamp: v = in_data >>> SHIFT; v<0 -> 0; v>131071 -> 131071; else v[16:0].
REQ-021 The write of beat 191 SHALL occur in the cycle in which the FSM is in FLUSH; data_done SHALL be 1 exactly in the DONE cycle, one cycle after the final write.
REQ-022 in_last=1 on a beat other than 191, or in_last=0 on beat 191, SHALL pulse frame_err in the following cycle; counting and writing SHALL continue unaffected.
REQ-023 Gaps in in_valid during FILL SHALL stall the counter without writes; no timeout.
REQ-024 s2_busy changes during FILL SHALL be ignored.
REQ-025 Latency from acceptance to bram_we SHALL be exactly 1 cycle; throughput 1 beat/cycle.

Reset
REQ-026 Asserting reset at any time SHALL force IDLE, counter=0, in_ready=0, bram_we=0, bram_addr=0, bram_din=0, data_done=0, busy=0, frame_err=0 (and ovf_count=0 when compiled in).
REQ-027 Reset mid-frame SHALL discard the partial frame; no data_done is issued for it.

Configuration
REQ-028 Macro S1_WRITER_OVF_COUNT_EN defined: add output ovf_count [7:0], counting beats clamped at 131071 (negatives not counted), saturating at 255, cleared on entry to FILL. Undefined: port and logic absent; all other behaviour identical.

Verification
REQ-029 s2_busy=0, 192 back-to-back beats in_data=k, in_last on k=191 -> bram_we on 192 consecutive cycles, addr=din=k, data_done one cycle after addr 191, no frame_err.
REQ-030 in_data=-5, 200000, 131071, with SHIFT=0 -> bram_din=0, 131071, 131071; SHIFT=2, in_data=400 -> 100.
REQ-031 s2_busy=1 at frame start -> in_ready stays 0 until s2_busy=0; after data_done, FSM holds in WAIT_ACK until s2_busy=1, then returns to IDLE.
REQ-032 in_last on beat 100 -> frame_err pulse on the next cycle, frame still completes at 192 beats with data_done.
REQ-033 reset asserted after beat 50 -> all outputs 0 asynchronously; the next full frame writes addr 0..191 normally.
REQ-034 With S1_WRITER_OVF_COUNT_EN, a frame containing 3 beats >131071 and 2 negative beats -> ovf_count=3 at data_done.

Source files
------------

// File: rtl/s1_bram_writer_if.sv
// Stage-1 writer bus: the result stream from the stage-1 producer, plus the
// BRAM write port that the writer drives.
//   in_valid/in_data/in_last : producer -> writer, beat qualifier, signed result, frame end
//   in_ready                 : writer -> producer, beat taken this cycle
//   bram_we/bram_addr/bram_din : writer -> BRAM write port
// Modports: master = producer/BRAM side, slave = writer side.
interface s1_bram_writer_if #(
    parameter int IN_WIDTH = 36
);
    logic                       in_valid;
    logic signed [IN_WIDTH-1:0] in_data;
    logic                       in_last;
    logic                       in_ready;
    logic                       bram_we;
    logic [7:0]                 bram_addr;
    logic [16:0]                bram_din;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, bram_we, bram_addr, bram_din
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/s1_bram_writer.sv
// s1_bram_writer: takes one 8x8x3 frame (192 signed stage-1 results), shifts
// and clamps each to 17-bit unsigned and writes it into BRAM at its beat
// index (cha*64 + row*8 + col). After the last write it pulses data_done and
// waits for the stage-2 consumer to raise s2_busy before taking a new frame.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   bus (slave)    : in_valid/in_data/in_last/in_ready stream, bram_we/addr/din
//   s2_busy        : stage-2 consumer busy
//   data_done      : one-cycle pulse once the frame is fully written
//   busy           : writer is not idle
//   frame_err      : one-cycle pulse when in_last disagrees with the beat count
//   ovf_count      : (only with S1_WRITER_OVF_COUNT_EN) beats clamped high, sat. 255
// Optional feature macro: S1_WRITER_OVF_COUNT_EN.
module s1_bram_writer #(
    parameter int IN_WIDTH = 36,
    parameter int SHIFT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    s1_bram_writer_if.slave   bus,
    input  logic              s2_busy,
    output logic              data_done,
    output logic              busy,
    output logic              frame_err
`ifdef S1_WRITER_OVF_COUNT_EN
    ,
    output logic [7:0]        ovf_count
`endif
);

    localparam logic [7:0] LAST_BEAT = 8'd191;
    localparam logic signed [IN_WIDTH-1:0] DIN_MAX = IN_WIDTH'(131071);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FLUSH,
        DONE,
        WAIT_ACK
    } state_t;

    state_t state, state_nxt;

    logic [7:0]                 cnt;
    logic                       accept;
    logic                       last_beat;
    logic                       entering_fill;
    logic signed [IN_WIDTH-1:0] shifted;
    logic                       over;
    logic [16:0]                din_clamped;

    assign accept        = bus.in_valid && (state == FILL);
    assign last_beat     = (cnt == LAST_BEAT);
    assign entering_fill = (state == IDLE) && !s2_busy;

    // Arithmetic shift keeps the sign, so negatives stay negative and clamp to 0.
    assign shifted     = $signed(bus.in_data) >>> SHIFT;
    assign over        = (shifted > DIN_MAX);
    assign din_clamped = shifted[IN_WIDTH-1] ? 17'd0 :
                         over                ? 17'h1ffff : shifted[16:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (!s2_busy) state_nxt = FILL;
            FILL:     if (accept && last_beat) state_nxt = FLUSH;
            FLUSH:    state_nxt = DONE;
            DONE:     state_nxt = WAIT_ACK;
            WAIT_ACK: if (s2_busy) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready = (state == FILL);
    assign data_done    = (state == DONE);
    assign busy         = (state != IDLE);

    // Write port is registered: the beat accepted in cycle N is written in
    // N+1, which puts the write of beat 191 in the FLUSH cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            bus.bram_we   <= 1'b0;
            bus.bram_addr <= '0;
            bus.bram_din  <= '0;
            frame_err     <= 1'b0;
        end else begin
            bus.bram_we <= accept;
            // in_last must be set on beat 191 and only there; flagging it
            // does not disturb counting or writing.
            frame_err   <= accept && (bus.in_last != last_beat);
            if (entering_fill)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + 8'd1;
            if (accept) begin
                bus.bram_addr <= cnt;
                bus.bram_din  <= din_clamped;
            end
        end
    end

`ifdef S1_WRITER_OVF_COUNT_EN
    // Cleared when a frame starts so the value stays readable after data_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_count <= '0;
        else if (entering_fill)
            ovf_count <= '0;
        else if (accept && over && (ovf_count != 8'hff))
            ovf_count <= ovf_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_s1_bram_writer.sv
// Randomized bench for s1_bram_writer. Two instances (SHIFT=0 and SHIFT=2)
// see identical stimulus; a frame-level reference model predicts handshake,
// status and every BRAM write.
module tb_s1_bram_writer;
    localparam int W = 36;
    localparam int P_IDLE = 0, P_FILL = 1, P_FLUSH = 2, P_DONE = 3, P_WAIT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s2_busy = 1'b0;
    logic done0, busy0, err0, done1, busy1, err1;
`ifdef S1_WRITER_OVF_COUNT_EN
    logic [7:0] ovf0, ovf1;
`endif

    s1_bram_writer_if #(.IN_WIDTH(W)) bus0 ();
    s1_bram_writer_if #(.IN_WIDTH(W)) bus1 ();

    always #5 clk = ~clk;

    s1_bram_writer #(.IN_WIDTH(W), .SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .s2_busy(s2_busy),
        .data_done(done0), .busy(busy0), .frame_err(err0)
`ifdef S1_WRITER_OVF_COUNT_EN
        , .ovf_count(ovf0)
`endif
    );

    s1_bram_writer #(.IN_WIDTH(W), .SHIFT(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .s2_busy(s2_busy),
        .data_done(done1), .busy(busy1), .frame_err(err1)
`ifdef S1_WRITER_OVF_COUNT_EN
        , .ovf_count(ovf1)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    // reference model
    int     phase;
    int     nbeat;
    int     m_ovf;
    bit     m_we, m_err;
    int     m_addr;
    longint m_din0, m_din1;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint clamp_ref(input longint x, input int sh);
        longint q;
        if (x < 0) return 0;
        q = x / (longint'(1) << sh);
        return (q > 131071) ? 131071 : q;
    endfunction

    function automatic logic signed [W-1:0] gen_data();
        longint v;
        case ($urandom_range(0, 7))
            0:       v = -longint'($urandom_range(1, 1000));
            1:       v = 131072 + longint'($urandom_range(0, 1000000));
            2:       v = 131071;
            3:       v = longint'($urandom);
            default: v = longint'($urandom_range(0, 131071));
        endcase
        return W'(v);
    endfunction

    task automatic model_reset();
        phase = P_IDLE; nbeat = 0; m_ovf = 0;
        m_we = 0; m_err = 0; m_addr = 0; m_din0 = 0; m_din1 = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_we"},    bus0.bram_we,   0);
        chk({tag, "_addr"},  bus0.bram_addr, 0);
        chk({tag, "_din"},   bus0.bram_din,  0);
        chk({tag, "_ready"}, bus0.in_ready,  0);
        chk({tag, "_done"},  done0,          0);
        chk({tag, "_busy"},  busy0,          0);
        chk({tag, "_err"},   err0,           0);
        chk({tag, "_din1"},  bus1.bram_din,  0);
`ifdef S1_WRITER_OVF_COUNT_EN
        chk({tag, "_ovf"},   ovf0,           0);
`endif
    endtask

    // One clock: called just after a falling edge, returns at the next one.
    task automatic tick(input bit v, input logic signed [W-1:0] d, input bit l,
                        input bit b, output bit acc);
        bus0.in_valid = v; bus0.in_data = d; bus0.in_last = l;
        bus1.in_valid = v; bus1.in_data = d; bus1.in_last = l;
        s2_busy = b;
        #1;
        chk("ready",  bus0.in_ready, phase == P_FILL);
        chk("ready1", bus1.in_ready, phase == P_FILL);
        chk("busy",   busy0,         phase != P_IDLE);
        chk("done",   done0,         phase == P_DONE);
        chk("done1",  done1,         phase == P_DONE);
`ifdef S1_WRITER_OVF_COUNT_EN
        if (phase == P_DONE) chk("ovf", ovf0, m_ovf);
`endif
        acc = v && (phase == P_FILL);
        m_we = acc;
        m_err = 0;
        if (acc) begin
            m_addr = nbeat;
            m_din0 = clamp_ref(longint'(d), 0);
            m_din1 = clamp_ref(longint'(d), 2);
            m_err  = (l != (nbeat == 191));
            if (longint'(d) > 131071 && m_ovf < 255) m_ovf++;
            nbeat++;
        end
        case (phase)
            P_IDLE:  if (!b) begin phase = P_FILL; nbeat = 0; m_ovf = 0; end
            P_FILL:  if (nbeat == 192) phase = P_FLUSH;
            P_FLUSH: phase = P_DONE;
            P_DONE:  phase = P_WAIT;
            default: if (b) phase = P_IDLE;
        endcase
        @(posedge clk);
        @(negedge clk);
        chk("we",    bus0.bram_we,   m_we);
        chk("we1",   bus1.bram_we,   m_we);
        chk("addr",  bus0.bram_addr, m_addr);
        chk("addr1", bus1.bram_addr, m_addr);
        chk("din",   bus0.bram_din,  m_din0);
        chk("din1",  bus1.bram_din,  m_din1);
        chk("ferr",  err0,           m_err);
        chk("ferr1", err1,           m_err);
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_zero("rst_mid");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // kind 0: data=k back to back; kind 1: directed clamp values then random
    // with gaps; kind 2: random with gaps and s2_busy toggling during fill.
    task automatic run_frame(input int kind, input int pre_busy, input int err_at, input int abort_at);
        bit acc;
        bit v, b;
        int k = 0;
        int guard = 0;
        logic signed [W-1:0] d;
        logic signed [W-1:0] dir [4];
        dir[0] = -36'sd5; dir[1] = 36'sd200000; dir[2] = 36'sd131071; dir[3] = 36'sd400;
        for (int i = 0; i < pre_busy; i++) tick(0, gen_data(), 0, 1, acc);
        while (phase != P_FILL && guard < 20) begin
            tick(0, gen_data(), 0, 0, acc);
            guard++;
        end
        if (guard >= 20) chk("fill_timeout", guard, 0);
        guard = 0;
        while (k < 192 && guard < 2000) begin
            v = (kind == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            b = (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!v)                     d = gen_data();
            else if (kind == 0)         d = W'(k);
            else if (kind == 1 && k < 4) d = dir[k];
            else                        d = gen_data();
            tick(v, d, v && (k == 191 || k == err_at), b, acc);
            if (acc) k++;
            guard++;
            if (abort_at >= 0 && k == abort_at) begin
                mid_reset();
                return;
            end
        end
        if (k < 192) chk("beat_timeout", k, 192);
        // FLUSH, DONE, then two WAIT_ACK cycles with s2_busy low, then ack
        for (int i = 0; i < 4; i++) tick(0, gen_data(), 0, 0, acc);
        tick(0, gen_data(), 0, 1, acc);
        tick(0, gen_data(), 0, 1, acc);
    endtask

    initial begin
        bus0.in_valid = 0; bus0.in_data = '0; bus0.in_last = 0;
        bus1.in_valid = 0; bus1.in_data = '0; bus1.in_last = 0;
        model_reset();
        @(negedge clk);
        check_zero("rst_init");
        @(negedge clk);
        reset = 1'b0;

        run_frame(0, 0, -1, -1);   // data=k back to back
        run_frame(1, 3, -1, -1);   // clamp corners, start held off by s2_busy
        run_frame(2, 5, 100, -1);  // in_last on beat 100
        run_frame(1, 0, -1, 51);   // reset after beat 50
        run_frame(0, 0, -1, -1);   // full frame after the aborted one
        run_frame(2, 2, -1, -1);
        run_frame(1, 1, -1, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", $time, 0);
        $fatal(1, "timeout");
    end
endmodule
